// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller with lock semantics.
// The current owner keeps the grant until it pulses done_i. On release, the
// priority pointer moves to the slot after the owner and the next winner is
// picked from the same-cycle requests, so back-to-back grants have no gap.
// gnt_valid_o is the registered FSM state (0 = IDLE, 1 = GRANT).

module rr_grant_ctrl #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               done_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      gnt_idx_o,
   output logic               gnt_valid_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e               state_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        gnt_idx_q;
   logic                 gnt_valid_q;
   logic [NUM_REQ-1:0]   gnt_q;

   logic [IW-1:0]        rel_ptr;
   logic [IW-1:0]        search_base;
   logic                 win_found;
   logic [IW-1:0]        win_idx;
   logic [NUM_REQ-1:0]   win_onehot;
   int                   cand;
   logic [IW-1:0]        cand_idx;

   // Slot after the current owner, wrapping explicitly so a non-power-of-two
   // NUM_REQ never produces an index >= NUM_REQ.
   assign rel_ptr     = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

   // In IDLE the search starts at the stored pointer; in GRANT the search is
   // only used on release, where it starts at the slot after the owner.
   assign search_base = (state_q == ST_GRANT) ? rel_ptr : ptr_q;

   // First asserted request in order search_base, search_base+1, ... (wrapping).
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(search_base) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IW'(cand);
         if (!win_found && req_i[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // One-hot decode of the winner, registered alongside its index.
   always_comb begin
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   // FSM with registered outputs; done_i is ignored in IDLE and req_i is
   // ignored in GRANT until the owner releases.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         gnt_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_found) begin
                  state_q     <= ST_GRANT;
                  gnt_idx_q   <= win_idx;
                  gnt_valid_q <= 1'b1;
                  gnt_q       <= win_onehot;
               end
            end
            ST_GRANT: begin
               if (done_i) begin
                  ptr_q <= rel_ptr;
                  if (win_found) begin
                     gnt_idx_q   <= win_idx;
                     gnt_valid_q <= 1'b1;
                     gnt_q       <= win_onehot;
                  end else begin
                     state_q     <= ST_IDLE;
                     gnt_idx_q   <= '0;
                     gnt_valid_q <= 1'b0;
                     gnt_q       <= '0;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               gnt_idx_q   <= '0;
               gnt_valid_q <= 1'b0;
               gnt_q       <= '0;
            end
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign gnt_valid_o = gnt_valid_q;

endmodule

// File: doc/rr_grant_ctrl.md
RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (legal values 2..32).
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port req_i, input, NUM_REQ bits, one request line per requester.
REQ-005 The block SHALL have port done_i, input, 1 bit, a pulse from the current owner that releases the grant.
REQ-006 The block SHALL have port gnt_o, output, NUM_REQ bits, the one-hot grant: the decode of gnt_idx_o, qualified by gnt_valid_o.
REQ-007 The block SHALL have port gnt_idx_o, output, $clog2(NUM_REQ) bits, the binary index of the current owner.
REQ-008 The block SHALL have port gnt_valid_o, output, 1 bit, high while a grant is held.

Function
REQ-009 The block SHALL implement a 2-state FSM: IDLE (no owner) and GRANT (owner held).
REQ-010 The block SHALL keep a priority pointer ptr (width of gnt_idx_o); search order ptr, ptr+1, ..., wrapping from NUM_REQ-1 to 0.
REQ-011 In IDLE, if req_i != 0, the block SHALL choose the first asserted request in search order, register it into gnt_idx_o, set gnt_valid_o, and go to GRANT; the grant SHALL be visible the cycle after req_i is sampled (1-cycle latency).
REQ-012 In IDLE with req_i == 0, all outputs SHALL hold zero, and done_i SHALL be ignored.
REQ-013 In GRANT, all outputs SHALL be held constant until done_i == 1, regardless of req_i, including the owner's own request deasserting (lock semantics).
REQ-014 On done_i == 1 in GRANT, ptr SHALL become (gnt_idx_o + 1) mod NUM_REQ.
REQ-015 On done_i == 1 in GRANT, the winner SHALL be searched from that new ptr over the same-cycle req_i.
REQ-016 On done_i == 1 in GRANT with a winner found, the block SHALL stay in GRANT with the new owner on the next cycle (back-to-back, no bubble).
REQ-017 On done_i == 1 in GRANT with no request asserted, the block SHALL go to IDLE with gnt_valid_o = 0 and gnt_o = 0 on the next cycle.
REQ-018 A requester that still requests on its own release SHALL be re-granted only if no other requester is asserted.
REQ-019 gnt_o SHALL always be all-zero or exactly one-hot, and SHALL equal 1 << gnt_idx_o whenever gnt_valid_o = 1.
REQ-020 gnt_idx_o SHALL never reach a value >= NUM_REQ, including for NUM_REQ values that are not a power of two.
REQ-021 Starvation bound: any requester holding req_i SHALL be granted within NUM_REQ-1 other grants.

Reset
REQ-022 While rst_ni == 0 at a clock edge, the block SHALL enter state IDLE on the next cycle.
REQ-023 While rst_ni == 0 at a clock edge, ptr, gnt_o, gnt_idx_o and gnt_valid_o SHALL all become 0 on the next cycle, regardless of req_i and done_i.
REQ-024 A reset asserted during GRANT SHALL drop the grant with no done_i required.
REQ-025 After reset, the first arbitration SHALL start from index 0.

Verification
REQ-026 NUM_REQ=4; rst_ni low 2 cycles with req_i=4'b1111 -> gnt_o=0000, gnt_valid_o=0 throughout; after release -> gnt_o=0001, gnt_idx_o=0 one cycle later.
REQ-027 NUM_REQ=4; req_i=1111 held, done_i pulsed on every grant cycle -> owners 0,1,2,3,0 on consecutive cycles, gnt_valid_o never drops.
REQ-028 NUM_REQ=4; owner 3, req_i=0011, done_i=1 -> next owner 0 (wrap), gnt_o=0001.
REQ-029 NUM_REQ=4; owner 1, req_i drops to 0000, done_i=0 for 5 cycles -> gnt_o stays 0010; done_i=1 -> gnt_o=0000, gnt_valid_o=0 next cycle.
REQ-030 NUM_REQ=4; owner 2, rst_ni=0 for one cycle with req_i=0100 -> outputs 0 next cycle; after release -> owner 2 granted from ptr=0.
REQ-031 NUM_REQ=3; req_i=111, done_i=1 every cycle -> owners 0,1,2,0,1,2; gnt_idx_o never 3.
